// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fs_state_t      : fetch FSM states
//   FS_RESET_PC     : default PC loaded by reset
//   FS_INST_NOP     : instruction word presented while IF/ID is empty
//   FS_ALIGN_MASK   : clears the byte-offset bits of a 32-bit address
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FS_BOOT  = 2'd0,
    FS_FETCH = 2'd1,
    FS_HOLD  = 2'd2,
    FS_DROP  = 2'd3
  } fs_state_t;

  localparam logic [31:0] FS_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] FS_INST_NOP   = 32'h0000_0000;
  localparam logic [31:0] FS_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus.
//   req   : fetch request, held until ack
//   addr  : word address, stable while req=1 and ack=0
//   ack   : memory returns rdata this cycle (may arrive in the request cycle)
//   rdata : fetched instruction
// master = fetch stage, slave = instruction memory.
interface fetch_stage_if #(
  parameter int W = 32
);
  logic         req;
  logic [W-1:0] addr;
  logic         ack;
  logic [W-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register.
//   clk, rst_n : clock, synchronous active-low reset (clears every field)
//   hold       : keep current contents (hazard stall); wins over everything else
//   load       : capture d_inst/d_pc/d_pc4 as a valid instruction
//   bubble     : insert an empty slot (valid=0, inst=NOP); pc/pc4 keep old values
//   d_*        : incoming instruction, its PC and PC+4
//   valid/inst/pc/pc4 : register contents; inst reads NOP whenever valid=0
module fetch_stage_ifid_reg
  import fetch_stage_pkg::*;
#(
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hold,
  input  logic                  load,
  input  logic                  bubble,
  input  logic [INST_WIDTH-1:0] d_inst,
  input  logic [INST_WIDTH-1:0] d_pc,
  input  logic [INST_WIDTH-1:0] d_pc4,
  output logic                  valid,
  output logic [INST_WIDTH-1:0] inst,
  output logic [INST_WIDTH-1:0] pc,
  output logic [INST_WIDTH-1:0] pc4
);

  localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(FS_INST_NOP);

  logic [INST_WIDTH-1:0] inst_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      inst_q <= NOP;
      pc     <= '0;
      pc4    <= '0;
    end else if (hold) begin
      valid  <= valid;
    end else if (load) begin
      valid  <= 1'b1;
      inst_q <= d_inst;
      pc     <= d_pc;
      pc4    <= d_pc4;
    end else if (bubble) begin
      valid  <= 1'b0;
      inst_q <= NOP;
    end
  end

  // The decoder sees NOP for an empty slot regardless of what was last stored.
  assign inst = valid ? inst_q : NOP;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
//   clk            : clock, all state updates on posedge
//   rst_n          : synchronous active-low reset
//   stall          : hazard unit asks IF/ID to hold this cycle
//   redirect_valid : decode has a taken BEQ/JAL; load redirect_pc (ignored under stall)
//   redirect_pc    : redirect target (byte-offset bits ignored)
//   imem           : instruction-memory bus, master side (single outstanding request)
//   ifid_valid     : IF/ID holds a real instruction
//   ifid_inst      : instruction, NOP when ifid_valid=0
//   ifid_pc        : PC of ifid_inst
//   ifid_pc4       : ifid_pc+4, JAL link value
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = FS_RESET_PC,
  parameter int          INST_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [INST_WIDTH-1:0]  redirect_pc,
  fetch_stage_if.master          imem,
  output logic                   ifid_valid,
  output logic [INST_WIDTH-1:0]  ifid_inst,
  output logic [INST_WIDTH-1:0]  ifid_pc,
  output logic [INST_WIDTH-1:0]  ifid_pc4
);

  localparam logic [INST_WIDTH-1:0] ALIGN = INST_WIDTH'(FS_ALIGN_MASK);
  localparam logic [INST_WIDTH-1:0] FOUR  = INST_WIDTH'(4);

  fs_state_t             state, state_n;
  logic [INST_WIDTH-1:0] pc, pc_n, pc_plus4;
  logic [INST_WIDTH-1:0] drop_addr;
  logic                  drop_we;

  logic                  skid_vld;
  logic [INST_WIDTH-1:0] skid_inst, skid_pc, skid_pc4;
  logic                  skid_we, skid_clr;

  logic                  ifid_load, ifid_from_skid;
  logic                  redirect;

  logic [INST_WIDTH-1:0] d_inst, d_pc, d_pc4;

  assign pc_plus4 = pc + FOUR;
  assign redirect = redirect_valid & ~stall;

  // Request is a pure decode of state. In DROP the bus keeps the abandoned
  // address so it stays stable until the memory acknowledges it.
  assign imem.req  = (state == FS_FETCH) || (state == FS_DROP);
  assign imem.addr = (state == FS_DROP) ? drop_addr : (pc & ALIGN);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FS_BOOT;
    end else begin
      state <= state_n;
    end
  end

  // Next state and datapath controls
  always_comb begin
    state_n        = state;
    pc_n           = pc;
    ifid_load      = 1'b0;
    ifid_from_skid = 1'b0;
    skid_we        = 1'b0;
    skid_clr       = 1'b0;
    drop_we        = 1'b0;

    case (state)
      FS_BOOT: begin
        state_n = FS_FETCH;
      end
      FS_FETCH: begin
        if (imem.ack) begin
          pc_n = pc_plus4;
          if (stall) begin
            skid_we = 1'b1;
            state_n = FS_HOLD;
          end else begin
            ifid_load = 1'b1;
          end
        end
      end
      FS_HOLD: begin
        if (!stall && skid_vld) begin
          ifid_load      = 1'b1;
          ifid_from_skid = 1'b1;
          skid_clr       = 1'b1;
          state_n        = FS_FETCH;
        end
      end
      FS_DROP: begin
        if (imem.ack) begin
          state_n = FS_FETCH;
        end
      end
      default: begin
        state_n = FS_BOOT;
      end
    endcase

    // A redirect squashes whatever this cycle would have delivered. A request
    // left hanging in FETCH has to be drained in DROP before the new PC is used.
    if (redirect) begin
      pc_n           = redirect_pc & ALIGN;
      ifid_load      = 1'b0;
      ifid_from_skid = 1'b0;
      skid_we        = 1'b0;
      skid_clr       = 1'b1;
      case (state)
        FS_FETCH: begin
          state_n = imem.ack ? FS_FETCH : FS_DROP;
          drop_we = ~imem.ack;
        end
        FS_DROP:  state_n = imem.ack ? FS_FETCH : FS_DROP;
        default:  state_n = FS_FETCH;
      endcase
    end
  end

  // PC, stale-address and skid registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      skid_vld <= 1'b0;
    end else begin
      pc <= pc_n;
      if (skid_we) begin
        skid_vld <= 1'b1;
      end else if (skid_clr) begin
        skid_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (drop_we) begin
      drop_addr <= pc & ALIGN;
    end
    if (skid_we) begin
      skid_inst <= imem.rdata;
      skid_pc   <= pc & ALIGN;
      skid_pc4  <= pc_plus4;
    end
  end

  assign d_inst = ifid_from_skid ? skid_inst : imem.rdata;
  assign d_pc   = ifid_from_skid ? skid_pc   : (pc & ALIGN);
  assign d_pc4  = ifid_from_skid ? skid_pc4  : pc_plus4;

  // IF/ID boundary
  fetch_stage_ifid_reg #(
    .INST_WIDTH (INST_WIDTH)
  ) u_ifid (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (stall),
    .load   (ifid_load),
    .bubble (~ifid_load),
    .d_inst (d_inst),
    .d_pc   (d_pc),
    .d_pc4  (d_pc4),
    .valid  (ifid_valid),
    .inst   (ifid_inst),
    .pc     (ifid_pc),
    .pc4    (ifid_pc4)
  );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_inst;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_stage_if #(.W(32)) bus ();

  fetch_stage #(
    .RESET_PC   (32'h0000_3000),
    .INST_WIDTH (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (bus.master),
    .ifid_valid     (ifid_valid),
    .ifid_inst      (ifid_inst),
    .ifid_pc        (ifid_pc),
    .ifid_pc4       (ifid_pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_ifid(input string tag, input logic v, input logic [31:0] inst,
                            input logic [31:0] pc, input logic [31:0] pc4);
    check({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, v});
    check({tag, ".inst"},  ifid_inst, inst);
    check({tag, ".pc"},    ifid_pc,   pc);
    check({tag, ".pc4"},   ifid_pc4,  pc4);
  endtask

  task automatic check_bus(input string tag, input logic req, input logic [31:0] addr);
    check({tag, ".req"}, {31'd0, bus.req}, {31'd0, req});
    if (req) check({tag, ".addr"}, bus.addr, addr);
  endtask

  initial begin
    logic [31:0] a;
    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    bus.ack        = 1'b0;
    bus.rdata      = 32'h0;

    // Reset state
    step();
    step();
    check_ifid("reset", 1'b0, 32'h0, 32'h0, 32'h0);
    check_bus("reset_boot", 1'b0, 32'h0);
    rst_n = 1'b1;
    step();
    check_bus("boot_to_fetch", 1'b1, 32'h0000_3000);

    // 1: same-cycle ack every cycle
    for (int i = 0; i < 3; i++) begin
      a = 32'h0000_3000 + 32'(4 * i);
      bus.ack   = 1'b1;
      bus.rdata = 32'h8C00_0000 | a;
      check_bus("stream", 1'b1, a);
      step();
      check_ifid("stream", 1'b1, 32'h8C00_0000 | a, a, a + 32'd4);
    end

    // 2: ack delayed three cycles
    bus.ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_bus("wait", 1'b1, 32'h0000_300C);
      step();
      check_ifid("wait_bubble", 1'b0, 32'h0, 32'h0000_3008, 32'h0000_300C);
    end
    bus.ack   = 1'b1;
    bus.rdata = 32'h8C00_300C;
    check_bus("late_ack", 1'b1, 32'h0000_300C);
    step();
    check_ifid("late_ack", 1'b1, 32'h8C00_300C, 32'h0000_300C, 32'h0000_3010);

    // 3: stall on the ack cycle, held two cycles
    bus.rdata = 32'h8C00_3010;
    stall     = 1'b1;
    step();
    bus.ack = 1'b0;
    check_ifid("stall1", 1'b1, 32'h8C00_300C, 32'h0000_300C, 32'h0000_3010);
    check_bus("hold1", 1'b0, 32'h0);
    step();
    check_ifid("stall2", 1'b1, 32'h8C00_300C, 32'h0000_300C, 32'h0000_3010);
    check_bus("hold2", 1'b0, 32'h0);
    stall = 1'b0;
    step();
    check_ifid("skid", 1'b1, 32'h8C00_3010, 32'h0000_3010, 32'h0000_3014);
    check_bus("after_skid", 1'b1, 32'h0000_3014);

    // 4: redirect with a request pending and no ack
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3100;
    step();
    redirect_valid = 1'b0;
    check_ifid("redir_bubble", 1'b0, 32'h0, 32'h0000_3010, 32'h0000_3014);
    check_bus("drop_stale", 1'b1, 32'h0000_3014);
    bus.ack   = 1'b1;
    bus.rdata = 32'hDEAD_BEEF;
    step();
    check_ifid("drop_discard", 1'b0, 32'h0, 32'h0000_3010, 32'h0000_3014);
    check_bus("after_drop", 1'b1, 32'h0000_3100);
    bus.rdata = 32'h8C00_3100;
    step();
    check_ifid("target", 1'b1, 32'h8C00_3100, 32'h0000_3100, 32'h0000_3104);

    // 5: redirect under stall is ignored, then reasserted without stall
    bus.ack        = 1'b0;
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3200;
    step();
    check_ifid("redir_stalled", 1'b1, 32'h8C00_3100, 32'h0000_3100, 32'h0000_3104);
    check_bus("redir_ignored", 1'b1, 32'h0000_3104);
    stall = 1'b0;
    step();
    check_ifid("redir_taken", 1'b0, 32'h0, 32'h0000_3100, 32'h0000_3104);
    check_bus("redir_drop", 1'b1, 32'h0000_3104);
    redirect_pc = 32'h0000_3302;
    step();
    redirect_valid = 1'b0;
    check_bus("redir_in_drop", 1'b1, 32'h0000_3104);
    bus.ack   = 1'b1;
    bus.rdata = 32'hDEAD_BEEF;
    step();
    check_bus("redir_overwrite", 1'b1, 32'h0000_3300);
    bus.rdata = 32'h8C00_3300;
    step();
    check_ifid("unaligned_target", 1'b1, 32'h8C00_3300, 32'h0000_3300, 32'h0000_3304);

    // 6a: reset while in HOLD
    bus.rdata = 32'h8C00_3304;
    stall     = 1'b1;
    step();
    bus.ack = 1'b0;
    check_bus("pre_rst_hold", 1'b0, 32'h0);
    stall = 1'b0;
    rst_n = 1'b0;
    step();
    check_ifid("rst_hold", 1'b0, 32'h0, 32'h0, 32'h0);
    check_bus("rst_hold", 1'b0, 32'h0);
    rst_n = 1'b1;
    step();
    check_bus("rst_hold_refetch", 1'b1, 32'h0000_3000);

    // 6b: reset while in DROP
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3400;
    step();
    redirect_valid = 1'b0;
    check_bus("pre_rst_drop", 1'b1, 32'h0000_3000);
    rst_n = 1'b0;
    step();
    check_ifid("rst_drop", 1'b0, 32'h0, 32'h0, 32'h0);
    check_bus("rst_drop", 1'b0, 32'h0);
    rst_n = 1'b1;
    step();
    check_bus("rst_drop_refetch", 1'b1, 32'h0000_3000);

    // Redirect coinciding with ack, then PC+4 wrap
    bus.ack        = 1'b1;
    bus.rdata      = 32'h8C00_3000;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check_ifid("redir_ack", 1'b0, 32'h0, 32'h0, 32'h0);
    check_bus("redir_ack_fetch", 1'b1, 32'hFFFF_FFFC);
    bus.rdata = 32'h1234_5678;
    step();
    check_ifid("wrap", 1'b1, 32'h1234_5678, 32'hFFFF_FFFC, 32'h0);
    check_bus("wrap_addr", 1'b1, 32'h0);
    bus.ack = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
